// File: rtl/data_sram_resp.sv
// data_sram_resp: responder side of the CPU data-SRAM port.
// Accepts a memory-stage request, waits WAIT cycles, then completes it.
//
// Ports:
//   clk     - clock, rising-edge state updates
//   rst     - asynchronous active-low reset
//   req     - request valid
//   wen     - byte write enables (4'b0000 = read)
//   addr    - byte address, word index is addr[ADDR_W+1:2]
//   wdata   - lane-aligned write data
//   addr_ok - request accepted this cycle when req is also 1
//   data_ok - one-cycle completion pulse
//   rdata   - read word, held between completions
//   err     - completed request was out of range (only with data_ok)

module data_sram_resp #(
    parameter int ADDR_W = 10,
    parameter int WAIT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [3:0]  wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        err
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } stateT;

    localparam logic [3:0] WaitLoad =
        (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

    logic [31:0] mem [0:(1 << ADDR_W) - 1];

    stateT             state;
    stateT             stateNext;
    logic [3:0]        cnt;
    logic [3:0]        cntNext;
    logic              readyQ;
    logic [3:0]        wenQ;
    logic [ADDR_W-1:0] idxQ;
    logic [31:0]       wdataQ;
    logic              oorQ;
    logic              respOor;
    logic [31:0]       rdataQ;

    logic              accept;
    logic              goResp;
    logic              reqOor;
    logic [ADDR_W-1:0] reqIdx;
    logic              fromLatch;
    logic [3:0]        opWen;
    logic [ADDR_W-1:0] opIdx;
    logic [31:0]       opData;
    logic              opOor;
    logic              unusedBits;

    assign unusedBits = ^addr[1:0];

    assign reqIdx = addr[ADDR_W+1:2];
    assign reqOor = |addr[31:ADDR_W+2];

    // Ready flag is registered so addr_ok stays low for the
    // first edge after reset release.
    assign addr_ok = readyQ && (state != StWait);
    assign accept  = req && addr_ok;
    assign data_ok = (state == StResp);
    assign err     = data_ok && respOor;
    assign rdata   = rdataQ;

    // With WAIT==0 the request enters RESP at its own acceptance
    // edge, so the operation comes straight from the inputs.
    assign fromLatch = (state == StWait);
    assign opWen  = fromLatch ? wenQ   : wen;
    assign opIdx  = fromLatch ? idxQ   : reqIdx;
    assign opData = fromLatch ? wdataQ : wdata;
    assign opOor  = fromLatch ? oorQ   : reqOor;

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        goResp    = 1'b0;
        unique case (state)
            StIdle, StResp: begin
                stateNext = StIdle;
                if (accept) begin
                    if (WAIT == 0) begin
                        stateNext = StResp;
                        goResp    = 1'b1;
                    end else begin
                        stateNext = StWait;
                        cntNext   = WaitLoad;
                    end
                end
            end
            StWait: begin
                if (cnt == 4'd0) begin
                    stateNext = StResp;
                    goResp    = 1'b1;
                end else begin
                    cntNext = cnt - 4'd1;
                end
            end
            default: stateNext = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= StIdle;
            cnt     <= 4'd0;
            readyQ  <= 1'b0;
            wenQ    <= 4'd0;
            idxQ    <= '0;
            wdataQ  <= 32'h0;
            oorQ    <= 1'b0;
            respOor <= 1'b0;
            rdataQ  <= 32'h0;
        end else begin
            state  <= stateNext;
            cnt    <= cntNext;
            readyQ <= 1'b1;
            if (accept) begin
                wenQ   <= wen;
                idxQ   <= reqIdx;
                wdataQ <= wdata;
                oorQ   <= reqOor;
            end
            if (goResp) begin
                respOor <= opOor;
                if (opOor) begin
                    rdataQ <= 32'h0;
                end else if (opWen == 4'd0) begin
                    rdataQ <= mem[opIdx];
                end
            end
        end
    end

    // goResp cannot fire while in reset: state is IDLE and the
    // ready flag is clear, so no write is committed then.
    always_ff @(posedge clk) begin
        if (goResp && !opOor) begin
            for (int i = 0; i < 4; i++) begin
                if (opWen[i]) begin
                    mem[opIdx][8*i +: 8] <= opData[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_sram_resp.sv
// tb_data_sram_resp: directed bench for data_sram_resp.
// Three instances cover WAIT=0, WAIT=2 and WAIT=4.

module tb_data_sram_resp;

    localparam int D0 = 0;
    localparam int D2 = 1;
    localparam int D4 = 2;

    logic        clk = 1'b0;
    logic        rstN   [3];
    logic        req    [3];
    logic [3:0]  wen    [3];
    logic [31:0] addr   [3];
    logic [31:0] wdata  [3];
    logic        addrOk [3];
    logic        dataOk [3];
    logic [31:0] rdata  [3];
    logic        err    [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_sram_resp #(.ADDR_W(10), .WAIT(0)) dut0 (
        .clk(clk), .rst(rstN[0]), .req(req[0]), .wen(wen[0]),
        .addr(addr[0]), .wdata(wdata[0]), .addr_ok(addrOk[0]),
        .data_ok(dataOk[0]), .rdata(rdata[0]), .err(err[0])
    );

    data_sram_resp #(.ADDR_W(10), .WAIT(2)) dut2 (
        .clk(clk), .rst(rstN[1]), .req(req[1]), .wen(wen[1]),
        .addr(addr[1]), .wdata(wdata[1]), .addr_ok(addrOk[1]),
        .data_ok(dataOk[1]), .rdata(rdata[1]), .err(err[1])
    );

    data_sram_resp #(.ADDR_W(10), .WAIT(4)) dut4 (
        .clk(clk), .rst(rstN[2]), .req(req[2]), .wen(wen[2]),
        .addr(addr[2]), .wdata(wdata[2]), .addr_ok(addrOk[2]),
        .data_ok(dataOk[2]), .rdata(rdata[2]), .err(err[2])
    );

    typedef struct {
        int          dut;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expErr;
        int          expLat;
    } vecT;

    vecT vecs[$];

    function automatic vecT mk(input int d, input logic [3:0] w,
                               input logic [31:0] a,
                               input logic [31:0] wd,
                               input logic [31:0] er,
                               input logic ee, input int el);
        vecT v;
        v.dut = d; v.wen = w; v.addr = a; v.wdata = wd;
        v.expRdata = er; v.expErr = ee; v.expLat = el;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where data_ok is seen.
    // lat counts negedges after the acceptance cycle.
    task automatic txn(input int d, input logic [3:0] w,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic e,
                       output int lat);
        int n;
        req[d] = 1'b1; wen[d] = w; addr[d] = a; wdata[d] = wd;
        n = 0;
        while (!addrOk[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL txn accept timeout: got busy required addr_ok");
        end
        @(negedge clk);
        req[d] = 1'b0;
        lat = 1;
        while (!dataOk[d] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 50) begin
            checks++; errors++;
            $display("FAIL txn data_ok timeout: got none required pulse");
        end
        rd = rdata[d];
        e  = err[d];
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat;
        int          seen;

        for (int d = 0; d < 3; d++) begin
            rstN[d] = 1'b0; req[d] = 1'b1; wen[d] = 4'h0;
            addr[d] = 32'h0; wdata[d] = 32'h0;
        end

        // Reset held for three cycles with req high.
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("rst%0d addr_ok", d), addrOk[d], 0);
                chk($sformatf("rst%0d data_ok", d), dataOk[d], 0);
                chk($sformatf("rst%0d err", d), err[d], 0);
                chk($sformatf("rst%0d rdata", d), rdata[d], 0);
            end
        end
        for (int d = 0; d < 3; d++) rstN[d] = 1'b1;
        chk("release addr_ok low", addrOk[D2], 0);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("ready%0d addr_ok", d), addrOk[d], 1);
            chk($sformatf("ready%0d data_ok", d), dataOk[d], 0);
            req[d] = 1'b0;
        end
        @(negedge clk);
        chk("idle data_ok", dataOk[D2], 0);

        vecs.push_back(mk(D2, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 0, 3));
        vecs.push_back(mk(D2, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 3));
        vecs.push_back(mk(D2, 4'hF, 32'h14, 32'h11223344, 32'hDEADBEEF, 0, 3));
        vecs.push_back(mk(D2, 4'h5, 32'h14, 32'hAABBCCDD, 32'hDEADBEEF, 0, 3));
        vecs.push_back(mk(D2, 4'h0, 32'h14, 32'h0, 32'h11BB33DD, 0, 3));
        vecs.push_back(mk(D2, 4'hF, 32'h0, 32'h12345678, 32'h11BB33DD, 0, 3));
        vecs.push_back(mk(D2, 4'hF, 32'h1000, 32'hFFFFFFFF, 32'h0, 1, 3));
        vecs.push_back(mk(D2, 4'h0, 32'h1000, 32'h0, 32'h0, 1, 3));
        vecs.push_back(mk(D2, 4'h0, 32'h0, 32'h0, 32'h12345678, 0, 3));
        vecs.push_back(mk(D2, 4'h0, 32'h3, 32'h0, 32'h12345678, 0, 3));
        vecs.push_back(mk(D2, 4'hF, 32'hFFC, 32'hCAFEF00D, 32'h12345678, 0, 3));
        vecs.push_back(mk(D2, 4'h0, 32'hFFC, 32'h0, 32'hCAFEF00D, 0, 3));
        vecs.push_back(mk(D2, 4'h0, 32'h80000000, 32'h0, 32'h0, 1, 3));
        vecs.push_back(mk(D2, 4'h0, 32'hFFC, 32'h0, 32'hCAFEF00D, 0, 3));
        vecs.push_back(mk(D0, 4'hF, 32'h40, 32'h5A5A5A5A, 32'h0, 0, 1));
        vecs.push_back(mk(D0, 4'h0, 32'h40, 32'h0, 32'h5A5A5A5A, 0, 1));
        vecs.push_back(mk(D4, 4'hF, 32'h20, 32'h55AA55AA, 32'h0, 0, 5));
        vecs.push_back(mk(D4, 4'h0, 32'h20, 32'h0, 32'h55AA55AA, 0, 5));

        foreach (vecs[i]) begin
            txn(vecs[i].dut, vecs[i].wen, vecs[i].addr, vecs[i].wdata,
                rd, e, lat);
            chk($sformatf("row%0d rdata", i), rd, vecs[i].expRdata);
            chk($sformatf("row%0d err", i), e, vecs[i].expErr);
            chk($sformatf("row%0d latency", i), lat, vecs[i].expLat);
            @(negedge clk);
            chk($sformatf("row%0d pulse", i), dataOk[vecs[i].dut], 0);
        end

        // WAIT=0 streaming: 8 writes then 8 reads, req held high.
        for (int k = 0; k < 16; k++) begin
            req[D0]   = 1'b1;
            wen[D0]   = (k < 8) ? 4'hF : 4'h0;
            addr[D0]  = 32'((k % 8) * 4);
            wdata[D0] = 32'(k % 8);
            @(negedge clk);
            chk($sformatf("stream%0d data_ok", k), dataOk[D0], 1);
            chk($sformatf("stream%0d addr_ok", k), addrOk[D0], 1);
            if (k >= 8)
                chk($sformatf("stream%0d rdata", k), rdata[D0], 32'(k - 8));
        end
        req[D0] = 1'b0;
        @(negedge clk);
        chk("stream end data_ok", dataOk[D0], 0);

        // Reset in the second WAIT cycle of a WAIT=4 write.
        req[D4] = 1'b1; wen[D4] = 4'hF;
        addr[D4] = 32'h20; wdata[D4] = 32'h0BAD0BAD;
        chk("midrst accept", addrOk[D4], 1);
        @(negedge clk);
        req[D4] = 1'b0;
        chk("midrst busy", addrOk[D4], 0);
        @(negedge clk);
        rstN[D4] = 1'b0;
        @(negedge clk);
        chk("midrst addr_ok", addrOk[D4], 0);
        chk("midrst data_ok", dataOk[D4], 0);
        chk("midrst rdata", rdata[D4], 0);
        rstN[D4] = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (dataOk[D4]) seen++;
        end
        chk("midrst no data_ok", seen, 0);
        txn(D4, 4'h0, 32'h20, 32'h0, rd, e, lat);
        chk("midrst word8", rd, 32'h55AA55AA);
        chk("midrst err", e, 0);
        chk("midrst latency", lat, 5);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
